sw_array_feeder: RTL and testbench
==================================

# sw_array_feeder

Upstream sequencer for the Smith-Waterman systolic PE chain. It accepts a query stream and a reference stream (2-bit bases, valid/ready) and drives the first PE's S/store_S/T/init inputs. It loads exactly NUM_PE query bases, streams the reference with init asserted, then drains the array with init low so the next alignment starts from zeroed PEs.

## Interface
- NUM_PE, 16: PE count in the chain; also the number of query bases per alignment and the drain length.
- CNT_W, 16: width of the reference-base counter.

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin alignment; sampled only in IDLE
- q_valid  in  1  query base valid
- q_data  in  2  query base
- q_ready  out  1  query base accepted when q_valid&q_ready
- r_valid  in  1  reference base valid
- r_data  in  2  reference base
- r_last  in  1  marks final reference base
- r_ready  out  1  reference base accepted when r_valid&r_ready
- S_out  out  2  query base to PE0 S_in
- store_S_out  out  1  to PE0 store_S_in
- T_out  out  2  reference base to PE0 T_in
- init_out  out  1  to PE0 init_in
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at end of DRAIN
- ref_count  out  CNT_W  reference bases accepted this alignment
- err  out  1  sticky underrun flag

## Operation
- States: IDLE, LOADQ, REF, DRAIN.
- IDLE: q_ready=r_ready=0, all PE-side outputs 0. start=1 -> LOADQ; clear q_cnt, ref_count, err.
- LOADQ: q_ready=1. Each accepted base registers S_out=q_data, store_S_out=1. Cycles without acceptance: store_S_out=0, S_out holds. Bubbles are legal: each base travels down the chain with its store flag. After the NUM_PE-th acceptance -> REF.
- REF: r_ready=1. Accepted base registers T_out=r_data, init_out=1, ref_count+1 (saturates at all-ones). Accepted base with r_last=1 -> DRAIN, clear drain counter.
- REF with r_valid=0 (underrun): registers init_out=0, T_out=0. Handling depends on SW_FEED_UNDERRUN_CHECK_EN.
- DRAIN: init_out=0, T_out=0, store_S_out=0 for NUM_PE cycles. On the last cycle, done=1 -> IDLE.
- Query/ref not accepted outside their states; start ignored when busy.
- All PE-side outputs are registered (flop outputs). The query-base counter is width clog2(NUM_PE+1).

## Timing
- Reset: state IDLE; q_ready, r_ready, S_out, store_S_out, T_out, init_out, busy, done, ref_count, err all 0. rst mid-alignment aborts immediately to IDLE the next edge; no done pulse.
- start accepted at edge k: busy=1 and q_ready=1 from k+1.
- A base accepted at edge k appears on S_out/T_out at k+1. Ready outputs are state-only, not combinational from valid.
- The first reference base may be accepted the cycle after the last query base: no gap is required or inserted.
- Alignment with L refs and gapless streams: start + NUM_PE query cycles + L ref cycles + NUM_PE drain cycles. done is asserted at cycle 2·NUM_PE+L+1 after start.
- r_last on the first ref base is legal (L=1).
- ref_count is valid from the acceptance edge. It holds its value in DRAIN and IDLE until the next start.

## Configuration
- SW_FEED_UNDERRUN_CHECK_EN defined: an underrun in REF sets err (sticky until next start) and forces the transition to DRAIN. Remaining reference bases are not accepted (r_ready=0) and the alignment ends with done.
- Undefined: err is tied to 0. An underrun only deasserts init_out for that cycle and REF continues. The caller must guarantee a gapless reference stream.

## Test plan
- Reset, NUM_PE=4: rst high 2 cycles -> all outputs 0, state IDLE; q_valid=1 ignored (q_ready=0).
- Gapless alignment, NUM_PE=4, query 0,1,2,3, ref 3,2,1,0 with r_last on the 4th -> store_S_out high 4 cycles with S_out 0,1,2,3; init_out high 4 cycles with T_out 3,2,1,0; done at cycle 13 after start; ref_count=4.
- Query bubbles: q_valid pattern 1,0,1,0,1,1 -> store_S_out follows acceptance one cycle later with S_out holding during bubbles; REF entered after 4th acceptance.
- Underrun, macro defined: r_valid drops after 2 refs -> err=1, DRAIN entered, done 4 cycles later, ref_count=2. Macro undefined: init_out low one cycle, err=0, REF continues.
- Reset mid-REF: rst after 2 ref bases -> next edge IDLE, init_out=0, no done; subsequent start runs a clean alignment.
- start held high throughout: start ignored while busy; the second alignment begins the cycle after done.

Source files
------------

// File: rtl/sw_array_feeder.sv
// sw_array_feeder: loads query bases, streams reference bases, then drains the SW PE chain.
// Optional macro SW_FEED_UNDERRUN_CHECK_EN: a reference underrun sets err and forces the drain.
module sw_array_feeder #(
  parameter int NUM_PE = 16,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             q_valid,
  input  logic [1:0]       q_data,
  output logic             q_ready,
  input  logic             r_valid,
  input  logic [1:0]       r_data,
  input  logic             r_last,
  output logic             r_ready,
  output logic [1:0]       S_out,
  output logic             store_S_out,
  output logic [1:0]       T_out,
  output logic             init_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] ref_count,
  output logic             err
);

  localparam int QW = $clog2(NUM_PE + 1);
  localparam logic [QW-1:0] LAST = QW'(NUM_PE - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOADQ,
    REF,
    DRAIN
  } state_t;

  state_t state;
  state_t state_nx;

  logic [QW-1:0] q_cnt;
  logic [QW-1:0] d_cnt;

  logic go;
  logic q_acc;
  logic r_acc;
  logic q_end;
  logic r_end;
  logic d_end;

  assign q_ready = (state == LOADQ);
  assign r_ready = (state == REF);
  assign busy    = (state != IDLE);

  assign go    = (state == IDLE) & start;
  assign q_acc = q_valid & q_ready;
  assign r_acc = r_valid & r_ready;
  assign q_end = q_acc & (q_cnt == LAST);
  assign r_end = r_acc & r_last;
  assign d_end = (state == DRAIN) & (d_cnt == LAST);

`ifdef SW_FEED_UNDERRUN_CHECK_EN
  logic under;
  logic err_q;

  assign under = r_ready & ~r_valid;
  assign err   = err_q;

  // Sticky underrun flag, cleared when a new alignment starts.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (go) begin
      err_q <= 1'b0;
    end else if (under) begin
      err_q <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start) state_nx = LOADQ;
      end
      LOADQ: begin
        if (q_end) state_nx = REF;
      end
      REF: begin
        if (r_end) state_nx = DRAIN;
`ifdef SW_FEED_UNDERRUN_CHECK_EN
        if (under) state_nx = DRAIN;
`endif
      end
      DRAIN: begin
        if (d_end) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Query/reference counters; the drain counter idles at zero outside DRAIN.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_cnt     <= '0;
      d_cnt     <= '0;
      ref_count <= '0;
    end else begin
      if (go) begin
        q_cnt     <= '0;
        ref_count <= '0;
      end else begin
        if (q_acc) begin
          q_cnt <= q_cnt + QW'(1);
        end
        if (r_acc && (ref_count != '1)) begin
          ref_count <= ref_count + CNT_W'(1);
        end
      end
      if (state == DRAIN) begin
        d_cnt <= d_cnt + QW'(1);
      end else begin
        d_cnt <= '0;
      end
    end
  end

  // Registered PE-side outputs; S_out holds through bubbles and clears on return to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      S_out       <= '0;
      store_S_out <= 1'b0;
      T_out       <= '0;
      init_out    <= 1'b0;
      done        <= 1'b0;
    end else begin
      store_S_out <= q_acc;
      init_out    <= r_acc;
      T_out       <= r_acc ? r_data : 2'b00;
      done        <= d_end;
      if (q_acc) begin
        S_out <= q_data;
      end else if (state_nx == IDLE) begin
        S_out <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sw_array_feeder.sv
// tb_sw_array_feeder: directed scoreboard bench for sw_array_feeder with NUM_PE=4.
// Underrun expectations follow SW_FEED_UNDERRUN_CHECK_EN.
`timescale 1ns/1ps
module tb_sw_array_feeder;

  localparam int NP = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          q_valid;
  logic [1:0]    q_data;
  logic          q_ready;
  logic          r_valid;
  logic [1:0]    r_data;
  logic          r_last;
  logic          r_ready;
  logic [1:0]    S_out;
  logic          store_S_out;
  logic [1:0]    T_out;
  logic          init_out;
  logic          busy;
  logic          done;
  logic [CW-1:0] ref_count;
  logic          err;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int tstart = 0;
  int done_n = 0;
  int d0;

  logic [1:0] s_q[$];
  logic [1:0] t_q[$];

  sw_array_feeder #(
    .NUM_PE(NP),
    .CNT_W (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .q_valid    (q_valid),
    .q_data     (q_data),
    .q_ready    (q_ready),
    .r_valid    (r_valid),
    .r_data     (r_data),
    .r_last     (r_last),
    .r_ready    (r_ready),
    .S_out      (S_out),
    .store_S_out(store_S_out),
    .T_out      (T_out),
    .init_out   (init_out),
    .busy       (busy),
    .done       (done),
    .ref_count  (ref_count),
    .err        (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: pops expected bases whenever the PE-side strobes fire.
  always @(negedge clk) begin
    if (done === 1'b1) done_n++;
    if (store_S_out === 1'b1) begin
      chk("s_avail", 32'(s_q.size() > 0), 32'd1);
      if (s_q.size() > 0) chk("S_out", 32'(S_out), 32'(s_q.pop_front()));
    end
    if (init_out === 1'b1) begin
      chk("t_avail", 32'(t_q.size() > 0), 32'd1);
      if (t_q.size() > 0) chk("T_out", 32'(T_out), 32'(t_q.pop_front()));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_q(input logic [1:0] d);
    int n;
    n = 0;
    q_valid = 1'b1;
    q_data = d;
    while (!q_ready && n < 20) begin
      step();
      n++;
    end
    chk("q_hs", 32'(q_ready), 32'd1);
    if (q_ready) s_q.push_back(d);
    step();
    q_valid = 1'b0;
  endtask

  task automatic send_r(input logic [1:0] d, input logic last);
    int n;
    n = 0;
    r_valid = 1'b1;
    r_data = d;
    r_last = last;
    while (!r_ready && n < 20) begin
      step();
      n++;
    end
    chk("r_hs", 32'(r_ready), 32'd1);
    if (r_ready) t_q.push_back(d);
    step();
    r_valid = 1'b0;
    r_last = 1'b0;
  endtask

  task automatic wait_done(input int want, input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 60) begin
      step();
      n++;
    end
    chk(tag, 32'(cyc - tstart), 32'(want));
  endtask

  task automatic go_start();
    start = 1'b1;
    tstart = cyc;
    step();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    q_valid = 1'b1;
    q_data = 2'd3;
    r_valid = 1'b0;
    r_data = 2'd0;
    r_last = 1'b0;
    step();
    step();
    chk("rst_outs",
        32'({q_ready, r_ready, S_out, store_S_out, T_out,
             init_out, busy, done, err}), 32'd0);
    chk("rst_refcnt", 32'(ref_count), 32'd0);
    rst = 1'b0;
    step();
    chk("idle_qready", 32'(q_ready), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_store", 32'(store_S_out), 32'd0);
    q_valid = 1'b0;
    step();

    // Gapless alignment.
    go_start();
    chk("start_rdy", 32'({busy, q_ready, r_ready}), 32'b110);
    send_q(2'd0);
    send_q(2'd1);
    send_q(2'd2);
    send_q(2'd3);
    chk("ref_entry", 32'(r_ready), 32'd1);
    send_r(2'd3, 1'b0);
    send_r(2'd2, 1'b0);
    send_r(2'd1, 1'b0);
    send_r(2'd0, 1'b1);
    chk("drain_rdy", 32'({busy, r_ready}), 32'b10);
    wait_done(13, "done_cyc_gapless");
    chk("refcnt_gapless", 32'(ref_count), 32'd4);
    step();
    chk("done_pulse", 32'({done, busy}), 32'd0);
    chk("idle_S", 32'(S_out), 32'd0);
    chk("refcnt_hold", 32'(ref_count), 32'd4);

    // Query bubbles 1,0,1,0,1,1 and a single-base reference.
    go_start();
    send_q(2'd1);
    chk("bub_store1", 32'({store_S_out, S_out}), 32'b101);
    step();
    chk("bub_hold1", 32'({store_S_out, S_out}), 32'b001);
    send_q(2'd2);
    step();
    chk("bub_hold2", 32'({store_S_out, S_out}), 32'b010);
    chk("bub_noref", 32'(r_ready), 32'd0);
    send_q(2'd3);
    send_q(2'd0);
    chk("bub_ref", 32'(r_ready), 32'd1);
    send_r(2'd1, 1'b1);
    wait_done(12, "done_cyc_bubble");
    chk("refcnt_l1", 32'(ref_count), 32'd1);
    step();

    // Reference underrun after two bases.
    go_start();
    send_q(2'd2);
    send_q(2'd2);
    send_q(2'd1);
    send_q(2'd1);
    send_r(2'd0, 1'b0);
    send_r(2'd1, 1'b0);
    step();
`ifdef SW_FEED_UNDERRUN_CHECK_EN
    chk("ur_err", 32'(err), 32'd1);
    chk("ur_drain", 32'({busy, r_ready, init_out}), 32'b100);
    wait_done(12, "done_cyc_underrun");
    chk("ur_refcnt", 32'(ref_count), 32'd2);
    chk("ur_err_hold", 32'(err), 32'd1);
`else
    chk("ur_err", 32'(err), 32'd0);
    chk("ur_cont", 32'({r_ready, init_out, T_out}), 32'b1000);
    send_r(2'd2, 1'b0);
    send_r(2'd3, 1'b1);
    wait_done(14, "done_cyc_underrun");
    chk("ur_refcnt", 32'(ref_count), 32'd4);
`endif
    step();

    // Reset in the middle of REF.
    go_start();
    chk("err_clear", 32'(err), 32'd0);
    send_q(2'd3);
    send_q(2'd2);
    send_q(2'd1);
    send_q(2'd0);
    send_r(2'd1, 1'b0);
    send_r(2'd2, 1'b0);
    rst = 1'b1;
    d0 = done_n;
    step();
    rst = 1'b0;
    chk("mid_rst", 32'({busy, init_out, r_ready, q_ready}), 32'd0);
    repeat (8) step();
    chk("mid_rst_nodone", 32'(done_n), 32'(d0));
    chk("mid_rst_idle", 32'(busy), 32'd0);
    chk("sq_empty", 32'(s_q.size()), 32'd0);
    chk("tq_empty", 32'(t_q.size()), 32'd0);

    // start held high across two alignments.
    start = 1'b1;
    tstart = cyc;
    step();
    send_q(2'd3);
    send_q(2'd0);
    chk("held_busy", 32'({busy, q_ready}), 32'b11);
    send_q(2'd3);
    send_q(2'd0);
    send_r(2'd2, 1'b0);
    send_r(2'd3, 1'b1);
    wait_done(11, "done_cyc_held1");
    tstart = cyc;
    step();
    chk("held_restart", 32'({busy, q_ready, done}), 32'b110);
    send_q(2'd1);
    start = 1'b0;
    send_q(2'd1);
    send_q(2'd2);
    send_q(2'd2);
    send_r(2'd1, 1'b1);
    wait_done(10, "done_cyc_held2");
    chk("held_refcnt", 32'(ref_count), 32'd1);
    step();
    step();
    chk("end_idle", 32'(busy), 32'd0);
    chk("end_sq", 32'(s_q.size()), 32'd0);
    chk("end_tq", 32'(t_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
